// File: rtl/mips_mem_pkg.sv
// Shared memory-path definitions: size encodings, store unit states and byte-lane mapping.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ERR
    } snu_state_e;

    // Lanes are computed little-endian, then mirrored for big-endian; bit3 = bits 31:24.
    function automatic logic [3:0] be_for(size_e size, logic [1:0] addr_lo, bit big_endian);
        logic [3:0] le;
        le = '0;
        case (size)
            SZ_BYTE: le = 4'b0001 << addr_lo;
            SZ_HALF: le = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: le = '1;
            default: le = '0;
        endcase
        return big_endian ? {le[0], le[1], le[2], le[3]} : le;
    endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Store request and data-memory write bus; the unit takes the slave side.
interface store_narrow_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        align_err;
    logic        bus_err;
    logic [31:0] err_addr;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
               done, align_err, bus_err, err_addr
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
               done, align_err, bus_err, err_addr
    );
endinterface

// File: rtl/store_narrow_unit_lane_gen.sv
// Combinational lane generator: byte enables, replicated write data and legality of a store.
module store_lane_gen
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        legal_o
);

    always_comb begin
        wdata_o = data_i;
        legal_o = 1'b0;
        case (size_e'(size_i))
            SZ_BYTE: begin
                wdata_o = {4{data_i[7:0]}};
                legal_o = 1'b1;
            end
            SZ_HALF: begin
                wdata_o = {2{data_i[15:0]}};
                legal_o = ~addr_lo_i[0];
            end
            SZ_WORD: legal_o = (addr_lo_i == 2'b00);
            default: legal_o = 1'b0;
        endcase
        be_o = be_for(size_e'(size_i), addr_lo_i, BIG_ENDIAN);
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: accepts a MEM-stage store, issues one aligned memory write, flags faults.
module store_narrow_unit
    import mips_mem_pkg::*;
#(
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                clk,
    input logic                rst,
    store_narrow_unit_if.slave bus
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    snu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic          done_q, done_d;
    logic          bus_err_q, bus_err_d;

    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic          lane_legal;

    store_lane_gen #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .size_i    (bus.req_size),
        .addr_lo_i (bus.req_addr[1:0]),
        .data_i    (bus.req_data),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .legal_o   (lane_legal)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        err_addr_d  = err_addr_q;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (lane_legal) begin
                        addr_d      = bus.req_addr;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = lane_wdata;
                        mem_be_d    = lane_be;
                        cnt_d       = '0;
                        state_d     = ST_ISSUE;
                    end else begin
                        err_addr_d = bus.req_addr;
                        state_d    = ST_ERR;
                    end
                end
            end
            ST_ISSUE: begin
                // mem_ready takes priority over a timeout expiring in the same cycle.
                if (bus.mem_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == LIMIT)) begin
                    bus_err_d  = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            err_addr_q  <= '0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            err_addr_q  <= err_addr_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.mem_valid = (state_q == ST_ISSUE);
    assign bus.align_err = (state_q == ST_ERR);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.done      = done_q;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit (big-endian, TIMEOUT=16) with immediate-assertion checks.
module tb_store_narrow_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    store_narrow_unit_if bus ();

    store_narrow_unit #(.BIG_ENDIAN(1'b1), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = s;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = 2'b00;
        bus.mem_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_be",    32'(bus.mem_be),    32'd0);
        chk("rst_mem_addr",  bus.mem_addr,       32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
        chk("rst_err_addr",  bus.err_addr,       32'd0);
        chk("rst_pulses",    {29'd0, bus.done, bus.align_err, bus.bus_err}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // BE byte store, ready immediately
        bus.mem_ready = 1'b1;
        req(32'h0000_1002, 32'h1234_56AB, 2'b00);
        chk("byte_valid", 32'(bus.mem_valid), 32'd1);
        chk("byte_ready", 32'(bus.req_ready), 32'd0);
        chk("byte_addr",  bus.mem_addr,       32'h0000_1000);
        chk("byte_be",    32'(bus.mem_be),    32'b0010);
        chk("byte_wdata", bus.mem_wdata,      32'hABAB_ABAB);
        chk("byte_done_early", 32'(bus.done), 32'd0);
        tick();
        chk("byte_done",  32'(bus.done),      32'd1);
        chk("byte_valid_off", 32'(bus.mem_valid), 32'd0);
        chk("byte_ready_back", 32'(bus.req_ready), 32'd1);

        // BE byte store at lane 3
        req(32'h0000_0013, 32'hFFFF_FF77, 2'b00);
        chk("byte3_be",    32'(bus.mem_be), 32'b0001);
        chk("byte3_wdata", bus.mem_wdata,   32'h7777_7777);
        tick();
        chk("byte3_done",  32'(bus.done),   32'd1);

        // BE half store
        req(32'h0000_2000, 32'hFFFF_BEEF, 2'b01);
        chk("half_be",    32'(bus.mem_be), 32'b1100);
        chk("half_wdata", bus.mem_wdata,   32'hBEEF_BEEF);
        chk("half_addr",  bus.mem_addr,    32'h0000_2000);
        tick();
        chk("half_done",  32'(bus.done),   32'd1);

        // Misaligned half
        req(32'h0000_2003, 32'h0000_1111, 2'b01);
        chk("mis_align_err", 32'(bus.align_err), 32'd1);
        chk("mis_err_addr",  bus.err_addr,       32'h0000_2003);
        chk("mis_valid",     32'(bus.mem_valid), 32'd0);
        chk("mis_ready",     32'(bus.req_ready), 32'd0);
        tick();
        chk("mis_pulse_end", 32'(bus.align_err), 32'd0);
        chk("mis_valid2",    32'(bus.mem_valid), 32'd0);
        chk("mis_no_done",   32'(bus.done),      32'd0);

        // Word store, mem_ready delayed 5 cycles
        bus.mem_ready = 1'b0;
        req(32'h0000_3000, 32'hCAFE_F00D, 2'b10);
        chk("word_be",    32'(bus.mem_be), 32'b1111);
        chk("word_wdata", bus.mem_wdata,   32'hCAFE_F00D);
        for (int i = 2; i <= 6; i++) begin
            tick();
            chk("word_hold_valid", 32'(bus.mem_valid), 32'd1);
            chk("word_hold_wdata", bus.mem_wdata,      32'hCAFE_F00D);
            chk("word_hold_addr",  bus.mem_addr,       32'h0000_3000);
            chk("word_hold_pulses", {30'd0, bus.done, bus.bus_err}, 32'd0);
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("word_done",    32'(bus.done),      32'd1);
        chk("word_no_berr", 32'(bus.bus_err),   32'd0);
        chk("word_valid_off", 32'(bus.mem_valid), 32'd0);
        tick();
        chk("word_single_done", 32'(bus.done), 32'd0);

        // Timeout: mem_ready never rises
        req(32'h0000_4004, 32'h0BAD_0BAD, 2'b10);
        for (int i = 1; i <= 16; i++) begin
            chk("to_valid", 32'(bus.mem_valid), 32'd1);
            chk("to_no_berr", 32'(bus.bus_err), 32'd0);
            tick();
        end
        chk("to_valid_drop", 32'(bus.mem_valid), 32'd0);
        chk("to_bus_err",    32'(bus.bus_err),   32'd1);
        chk("to_err_addr",   bus.err_addr,       32'h0000_4004);
        chk("to_no_done",    32'(bus.done),      32'd0);
        tick();
        chk("to_pulse_end",  32'(bus.bus_err),   32'd0);

        // Timeout race: mem_ready on the final cycle wins
        req(32'h0000_5008, 32'h5555_AAAA, 2'b10);
        for (int i = 1; i <= 15; i++) begin
            chk("race_valid", 32'(bus.mem_valid), 32'd1);
            tick();
        end
        chk("race_valid16", 32'(bus.mem_valid), 32'd1);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("race_done",     32'(bus.done),    32'd1);
        chk("race_no_berr",  32'(bus.bus_err), 32'd0);
        chk("race_err_addr", bus.err_addr,     32'h0000_4004);

        // Reset in the 2nd cycle of ISSUE
        tick();
        req(32'h0000_6000, 32'h6666_6666, 2'b10);
        tick();
        chk("mid_valid", 32'(bus.mem_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_valid_off", 32'(bus.mem_valid), 32'd0);
        chk("mid_pulses", {29'd0, bus.done, bus.align_err, bus.bus_err}, 32'd0);
        chk("mid_err_addr", bus.err_addr, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_no_done",   32'(bus.done),      32'd0);

        // Reserved size at aligned and unaligned addresses
        req(32'h0000_7000, 32'h0, 2'b11);
        chk("rsvd0_align_err", 32'(bus.align_err), 32'd1);
        chk("rsvd0_err_addr",  bus.err_addr,       32'h0000_7000);
        chk("rsvd0_valid",     32'(bus.mem_valid), 32'd0);
        tick();
        req(32'h0000_7001, 32'h0, 2'b11);
        chk("rsvd1_align_err", 32'(bus.align_err), 32'd1);
        chk("rsvd1_err_addr",  bus.err_addr,       32'h0000_7001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the load-path sign extension: narrows a 32-bit register value to byte/halfword/word and issues one aligned write to data memory.
- Sits between the MEM-stage store request and the data-memory write port.
- Computes byte enables and lane-replicated write data, and runs a valid/ready handshake with memory.
- Detects misaligned stores and unsupported sizes, and bounds memory latency with a timeout.

Parameters:
- BIG_ENDIAN, 1, 1 = MIPS big-endian lane mapping; 0 = little-endian.
- TIMEOUT, 16, maximum cycles to wait for mem_ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  32  byte address.
- req_data  in  32  register data; the value sits in the low bits.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_valid  out  1  write request to memory.
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated data.
- mem_be  out  4  byte enables; bit3 = bits 31:24.
- done  out  1  one-cycle pulse: store completed.
- align_err  out  1  one-cycle pulse: misaligned address or reserved size.
- bus_err  out  1  one-cycle pulse: timeout abort.
- err_addr  out  32  address of the last faulting request; holds until the next error.

Behaviour:
- Reset (rst sampled high at posedge):
  - State goes to IDLE.
  - mem_valid, done, align_err, bus_err = 0; mem_addr, mem_wdata, err_addr = 0; mem_be = 4'b0000.
  - Timeout counter = 0.
  - req_ready = 1 in the cycle after reset.
- States: IDLE, ISSUE, ERR.
- IDLE:
  - req_ready = 1; a request is accepted when req_valid && req_ready.
  - On a legal request, all memory outputs are registered and the unit moves to ISSUE.
  - Legal means: byte at any address; half with addr[0]=0; word with addr[1:0]=0; size != 11.
  - On an illegal request: err_addr <= req_addr, move to ERR. No memory access is made.
- ERR:
  - Lasts exactly one cycle: align_err = 1, req_ready = 0.
  - Returns to IDLE.
- ISSUE:
  - mem_valid = 1, req_ready = 0. mem_addr, mem_wdata and mem_be stay stable until the handshake completes.
  - Handshake = mem_valid && mem_ready at a posedge. On handshake: return to IDLE, done = 1 in the next cycle.
  - Each cycle without mem_ready increments the counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without mem_ready: drop mem_valid, set err_addr, bus_err = 1 in the next cycle, return to IDLE.
  - If mem_ready arrives in the same cycle the timeout would fire, mem_ready wins: done, no bus_err.
  - The counter clears on every entry to ISSUE.
- Latency: request accepted in cycle T → mem_valid from T+1. With mem_ready high at T+1, done is high at T+2. Back-to-back stores accept every 2 cycles minimum.
- Write data:
  - byte: {4{req_data[7:0]}}
  - half: {2{req_data[15:0]}}
  - word: req_data
  - Upper bits of req_data are ignored for narrow sizes.
- Byte enables with BIG_ENDIAN=1, byte stores, by addr[1:0]:
  - 0 → 1000; 1 → 0100; 2 → 0010; 3 → 0001.
- Byte enables with BIG_ENDIAN=1, half stores:
  - addr[1]=0 → 1100; addr[1]=1 → 0011.
- With BIG_ENDIAN=0, byte and half lanes are mirrored.
- Word stores: mem_be = 1111.
- Reset mid-ISSUE: mem_valid = 0 from the next cycle; no done or error pulse is produced.
- done, align_err and bus_err are mutually exclusive in any cycle.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the state enum for this unit;
  - a be_for(size, addr_lo, big_endian) function. The load-path extender reuses it for lane selection.
- One combinational sub-module, store_lane_gen: size, addr[1:0] → mem_be, replicated wdata and legal flag. It is registered by the parent.

Test Plan:
- BE byte store: addr 0x00001002, data 0x123456AB, size 00, mem_ready high immediately → mem_addr 0x00001000, mem_be 0010, mem_wdata 0xABABABAB, done at T+2.
- BE half store: addr 0x00002000, data 0xFFFFBEEF, size 01 → mem_be 1100, mem_wdata 0xBEEFBEEF. Then addr 0x00002003, size 01 → align_err pulse, err_addr 0x00002003, mem_valid never rises.
- Word store with mem_ready delayed 5 cycles → mem_valid held and outputs stable for 6 cycles, single done, no bus_err.
- TIMEOUT=16, mem_ready held low → mem_valid drops after 16 cycles, bus_err one cycle, err_addr = request address. A repeat run with mem_ready rising exactly on the final cycle → done, no bus_err.
- rst asserted in the 2nd cycle of ISSUE → mem_valid 0 the next cycle, no done, req_ready 1 after reset. Also check that size 11 at any address → align_err.
